// File: rtl/seq_step_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_step_fsm_pkg
// Description : Shared types and helpers for the step-sequence controller.
//               Provides the controller state encoding and the masked
//               compare used to decide whether a word matches a step.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_step_fsm_pkg;

   // Widest data word the compare helper handles; callers zero-extend.
   localparam int SEQ_MAX_W = 32;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2,
      SEQ_ERR  = 2'd3
   } seq_state_t;

   // 1 when every bit selected by mask agrees between data and pat.
   function automatic logic seq_match(
      input logic [SEQ_MAX_W-1:0] data,
      input logic [SEQ_MAX_W-1:0] pat,
      input logic [SEQ_MAX_W-1:0] mask
   );
      return ((data ^ pat) & mask) == '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_step_fsm_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Per-step idle timeout counter. Loads a start value, counts
//               down while enabled and flags the last permitted cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load/load_val - reload the counter with load_val
//               en            - decrement this cycle (ignored at zero)
//               expire        - count is 1 and the timeout is enabled
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
   parameter int TMO_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMO_W-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [TMO_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - TMO_W'(1);
      end
   end

   // A zero load value disables the timeout entirely.
   assign expire = (r_count == TMO_W'(1)) && (load_val != '0);

endmodule
`default_nettype wire

// File: rtl/seq_step_fsm.sv
`default_nettype none
// ============================================================================
// Module      : seq_step_fsm
// Description : N-step sequence controller. Advances one step per input word
//               matching the current step's pattern under its mask, with a
//               programmable per-step timeout, abort, error state and a
//               one-cycle completion pulse. Outputs are registered (Moore).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, abort        - begin / cancel a sequence
//               data_valid, data_in - qualified input word
//               cfg_pattern/mask    - per-step pattern and compare mask
//               timeout_cycles      - idle cycles per step (0 = disabled)
//               step, busy, done, err - status to downstream control
// Revision    : 1.0 - initial release
// ============================================================================
module seq_step_fsm
   import seq_step_fsm_pkg::*;
#(
   parameter  int DATA_W  = 4,
   parameter  int N_STEPS = 5,
   parameter  int TMO_W   = 8,
   localparam int IDX_W   = $clog2(N_STEPS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      data_valid,
   input  logic [DATA_W-1:0]         data_in,
   input  logic [N_STEPS*DATA_W-1:0] cfg_pattern,
   input  logic [N_STEPS*DATA_W-1:0] cfg_mask,
   input  logic [TMO_W-1:0]          timeout_cycles,
   output logic [IDX_W-1:0]          step,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam logic [IDX_W-1:0] c_last_step = IDX_W'(N_STEPS - 1);
   localparam logic [IDX_W-1:0] c_done_step = IDX_W'(N_STEPS);

   seq_state_t                r_state;
   logic [IDX_W-1:0]          r_step;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_err;
   logic [N_STEPS*DATA_W-1:0] r_pat;
   logic [N_STEPS*DATA_W-1:0] r_mask;
   logic [TMO_W-1:0]          r_tmo;

   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_pat;
   logic [DATA_W-1:0] w_msk;
   logic              w_match;
   logic              w_run;
   logic              w_start_accept;
   logic              w_tmr_load;
   logic              w_tmr_en;
   logic [TMO_W-1:0]  w_tmr_val;
   logic              w_expire;

   // step reaches N_STEPS only in DONE; clamp so the slice stays in range.
   assign w_idx   = (r_step > c_last_step) ? '0 : r_step;
   assign w_pat   = r_pat[w_idx*DATA_W +: DATA_W];
   assign w_msk   = r_mask[w_idx*DATA_W +: DATA_W];
   assign w_match = data_valid &&
                    seq_match(SEQ_MAX_W'(data_in), SEQ_MAX_W'(w_pat), SEQ_MAX_W'(w_msk));

   assign w_run          = (r_state == SEQ_RUN);
   assign w_start_accept = start && ((r_state == SEQ_IDLE) || (r_state == SEQ_ERR));

   // The timer is loaded on the same edge the config is latched, so it must
   // take the port value then; afterwards the latched copy is the reference.
   assign w_tmr_val  = w_start_accept ? timeout_cycles : r_tmo;
   assign w_tmr_load = w_start_accept || (w_run && !abort && w_match);
   assign w_tmr_en   = w_run && !abort && !w_match;

   seq_timer #(
      .TMO_W (TMO_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .en       (w_tmr_en),
      .expire   (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEQ_IDLE;
         r_step  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_pat   <= '0;
         r_mask  <= '0;
         r_tmo   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_start_accept) begin
            r_state <= SEQ_RUN;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_pat   <= cfg_pattern;
            r_mask  <= cfg_mask;
            r_tmo   <= timeout_cycles;
         end else begin
            case (r_state)
               SEQ_IDLE: ;
               SEQ_RUN: begin
                  if (abort) begin
                     r_state <= SEQ_IDLE;
                     r_step  <= '0;
                     r_busy  <= 1'b0;
                  end else if (w_match) begin
                     if (r_step == c_last_step) begin
                        r_state <= SEQ_DONE;
                        r_step  <= c_done_step;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_step <= r_step + IDX_W'(1);
                     end
                  end else if (w_expire) begin
                     // step is kept so downstream can see which step failed
                     r_state <= SEQ_ERR;
                     r_busy  <= 1'b0;
                     r_err   <= 1'b1;
                  end
               end
               SEQ_DONE: begin
                  r_state <= SEQ_IDLE;
                  r_step  <= '0;
               end
               SEQ_ERR: begin
                  if (abort) begin
                     r_state <= SEQ_IDLE;
                     r_step  <= '0;
                     r_err   <= 1'b0;
                  end
               end
               default: begin
                  r_state <= SEQ_IDLE;
                  r_step  <= '0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign step = r_step;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule
`default_nettype wire
